flash_boot_loader: RTL and testbench
====================================

Name: flash_boot_loader

Overview:
- Boot sequencer that drives the SPI flash reader and copies its byte stream into the external Z8S180 SRAM.
- Holds the CPU in reset while loading, then releases it.
- Sits between the flash reader (read_en/active/tData/tValid stream) and the SRAM write port.
- Checks byte count, stream timing and overrun, and reports a 16-bit additive checksum.

Parameters:
- CLOCK_FREQ_HZ, 25000000, system clock frequency; sizes the timeout counter.
- NUM_BYTES, 65336, bytes expected from the flash reader; must match the reader's NUM_READ_BYTES.
- MEM_BASE, 0, first SRAM address written.
- MEM_ADDR_W, 19, SRAM address width.
- WE_CYCLES, 2, clocks mem_we_n is held low per write (min 1).
- TIMEOUT_US, 1000, maximum gap allowed between events while loading.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- retry  in  1  one-cycle pulse; restarts the load from DONE or ERROR.
- flash_read_en  out  1  enable to the flash reader.
- flash_read_active  in  1  flash reader is streaming bytes.
- flash_tData  in  8  byte from the flash reader.
- flash_tValid  in  1  one-cycle byte strobe.
- mem_addr  out  MEM_ADDR_W  SRAM address.
- mem_data  out  8  SRAM write data.
- mem_ce_n  out  1  SRAM chip enable, low active.
- mem_we_n  out  1  SRAM write enable, low active.
- cpu_reset_n  out  1  CPU reset; low while loading or in error.
- boot_done  out  1  load completed and verified.
- boot_error  out  1  load failed.
- byte_count  out  17  bytes written to SRAM.
- checksum  out  16  sum of written bytes, mod 2^16.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - flash_read_en=0, mem_ce_n=1, mem_we_n=1, cpu_reset_n=0, boot_done=0, boot_error=0.
  - mem_addr=MEM_BASE, mem_data=0xFF, byte_count=0, checksum=0.
  - Main state = START.
- Reset asserted mid-load aborts immediately to these values. flash_read_en drops the next cycle, which returns the reader to idle.
- Main FSM:
  - START: clear counters and error flag; set mem_addr=MEM_BASE; assert flash_read_en; go to LOAD.
  - LOAD:
    - Hold flash_read_en=1.
    - Track seen_active, set on the first cycle flash_read_active=1.
    - Leave LOAD when seen_active=1, flash_read_active=0 and the write engine is idle:
      - byte_count==NUM_BYTES -> DONE.
      - otherwise -> ERROR.
  - DONE: flash_read_en=0, boot_done=1, cpu_reset_n=1 (registered, one cycle after entry). retry -> START, with cpu_reset_n back to 0 in the same cycle.
  - ERROR: flash_read_en=0, boot_error=1, cpu_reset_n=0. retry -> START.
- Write engine: one-byte buffer with states W_IDLE, W_SETUP, W_STROBE, W_HOLD.
  - W_IDLE + flash_tValid in LOAD: latch flash_tData into mem_data; go to W_SETUP.
  - W_SETUP (1 cycle): mem_ce_n=0; mem_addr and mem_data stable.
  - W_STROBE: mem_we_n=0 for exactly WE_CYCLES cycles.
  - W_HOLD (1 cycle): mem_we_n=1, mem_ce_n=0. At exit: mem_addr+1, byte_count+1, checksum+=byte; mem_ce_n=1 next cycle; return to W_IDLE.
  - Write latency from tValid to first mem_we_n low = 2 cycles. Occupancy = WE_CYCLES+2 cycles per byte.
- Errors:
  - Overrun: flash_tValid while the engine is not W_IDLE -> ERROR. The in-flight write finishes its strobe first; WE is never truncated.
  - Extra byte: flash_tValid when byte_count==NUM_BYTES -> ERROR; the byte is not written.
  - Timeout:
    - Counter of TIMEOUT_US*CLOCK_FREQ_HZ/1e6 cycles; cleared on START, on each flash_tValid, and on any change of flash_read_active.
    - Reaching the count in LOAD -> ERROR (covers a reader that never activates).
- Address arithmetic: mem_addr wraps modulo 2^MEM_ADDR_W. No error on wrap; NUM_BYTES+MEM_BASE ≤ 2^MEM_ADDR_W is a parameter rule, checked by an elaboration assertion.
- flash_tValid outside LOAD is ignored.
- retry outside DONE or ERROR is ignored.

Decomposition:
- Shared package flash_boot_pkg:
  - Main state encoding: START, LOAD, DONE, ERROR.
  - Write-engine state encoding.
  - Error cause codes: NONE, OVERRUN, EXTRA, SHORT, TIMEOUT. These are exposed internally for debug.
- One natural sub-module: sram_byte_writer, the write engine with its buffer and strobe timing, reusable by a later CPU-side loader.
- The timeout counter stays inline.

Test Plan:
- Nominal: NUM_BYTES=4, bytes 0x11,0x22,0x33,0x44 at 20-cycle spacing, then active falls.
  - SRAM at MEM_BASE..+3 holds those bytes.
  - checksum=0x00AA, byte_count=4.
  - boot_done=1 and cpu_reset_n=1 one cycle after DONE.
- Strobe timing, WE_CYCLES=3: single tValid -> mem_ce_n low at T+1, mem_we_n low exactly T+2..T+4, mem_ce_n high at T+6.
- Overrun: second tValid 2 cycles after the first -> first write completes with a 3-cycle WE, boot_error=1, cpu_reset_n stays 0.
- Short stream: active falls after 3 of 4 bytes -> ERROR with cause SHORT, byte_count=3, flash_read_en=0.
- Timeout: flash_read_active never rises; TIMEOUT_US=1 at 25 MHz -> ERROR after 25 cycles.
- Recovery:
  - retry in ERROR -> START; flash_read_en rises again; a nominal stream then reaches DONE with checksum recomputed from 0.
  - Reset mid-LOAD -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/flash_boot_pkg.sv
// Shared types for the flash boot loader: main and write-engine state encodings,
// debug error causes, and timeout sizing.
package flash_boot_pkg;

    typedef enum logic [1:0] {
        ST_START,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } boot_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD
    } wr_state_e;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_OVERRUN,
        ERR_EXTRA,
        ERR_SHORT,
        ERR_TIMEOUT
    } err_cause_e;

    localparam logic [7:0] MEM_DATA_IDLE = 8'hFF;

    function automatic longint timeoutCycles(input longint freqHz, input longint timeoutUs);
        return (timeoutUs * freqHz) / 64'd1000000;
    endfunction

endpackage

// File: rtl/sram_byte_writer.sv
// One-byte buffered SRAM write engine: setup, WE_CYCLES-long strobe, hold.
// Address auto-increments after each completed write.
module sram_byte_writer
    import flash_boot_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 0,
    parameter int WE_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [7:0]        data_i,
    output logic              idle_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    output logic              mem_ce_n_o,
    output logic              mem_we_n_o
);

    localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [CW-1:0] LAST_STROBE = CW'(WE_CYCLES - 1);

    wr_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= W_IDLE;
            cnt_q   <= '0;
            addr_q  <= BASE;
            data_q  <= MEM_DATA_IDLE;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ce_n_q  <= ce_n_d;
            we_n_q  <= we_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            W_IDLE:   if (valid_i) state_d = W_SETUP;
            W_SETUP: begin
                state_d = W_STROBE;
                cnt_d   = '0;
            end
            W_STROBE: begin
                if (cnt_q == LAST_STROBE) state_d = W_HOLD;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            W_HOLD:   state_d = W_IDLE;
            default:  state_d = W_IDLE;
        endcase
    end

    // Strobes are registered from the next state so the SRAM sees glitch-free edges.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (state_q == W_IDLE && valid_i) data_d = data_i;
        if (state_q == W_HOLD)            addr_d = addr_q + 1'b1;
        else if (state_q == W_IDLE && clear_i) addr_d = BASE;
        ce_n_d = (state_d == W_IDLE);
        we_n_d = (state_d != W_STROBE);
    end

    assign idle_o     = (state_q == W_IDLE);
    assign done_o     = (state_q == W_HOLD);
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign mem_ce_n_o = ce_n_q;
    assign mem_we_n_o = we_n_q;

endmodule

// File: rtl/flash_boot_loader.sv
// Boot sequencer: streams the flash image into SRAM while holding the CPU in reset,
// validates count/timing/overrun, then releases the CPU.
module flash_boot_loader
    import flash_boot_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 25000000,
    parameter int NUM_BYTES     = 65336,
    parameter int MEM_BASE      = 0,
    parameter int MEM_ADDR_W    = 19,
    parameter int WE_CYCLES     = 2,
    parameter int TIMEOUT_US    = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  retry,
    output logic                  flash_read_en,
    input  logic                  flash_read_active,
    input  logic [7:0]            flash_tData,
    input  logic                  flash_tValid,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_ce_n,
    output logic                  mem_we_n,
    output logic                  cpu_reset_n,
    output logic                  boot_done,
    output logic                  boot_error,
    output logic [16:0]           byte_count,
    output logic [15:0]           checksum
);

    localparam longint TMO_RAW    = timeoutCycles(longint'(CLOCK_FREQ_HZ), longint'(TIMEOUT_US));
    localparam int     TMO_CYCLES = (TMO_RAW < 1) ? 1 : int'(TMO_RAW);
    localparam int     TMO_W      = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TMO_CYCLES - 1);
    localparam logic [16:0]      NUM_BYTES_C = 17'(NUM_BYTES);

    if (longint'(NUM_BYTES) + longint'(MEM_BASE) > (longint'(1) << MEM_ADDR_W)) begin : g_bad_map
        $error("flash_boot_loader: NUM_BYTES + MEM_BASE exceeds the SRAM address space");
    end
    if (WE_CYCLES < 1 || NUM_BYTES < 1 || NUM_BYTES > 131071) begin : g_bad_param
        $error("flash_boot_loader: WE_CYCLES or NUM_BYTES out of range");
    end

    boot_state_e      state_q, state_d;
    err_cause_e       err_cause_q, err_cause_d;
    logic             seen_active_q, seen_active_d;
    logic             active_q;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [16:0]      byte_count_q, byte_count_d;
    logic [15:0]      checksum_q, checksum_d;
    logic             read_en_q, read_en_d;
    logic             boot_done_q, boot_done_d;
    logic             boot_error_q, boot_error_d;
    logic             cpu_reset_n_q, cpu_reset_n_d;

    logic wr_idle, wr_done, wr_accept, wr_clear;
    logic count_full, tmo_clear, tmo_expired;

    assign count_full  = (byte_count_q == NUM_BYTES_C);
    assign tmo_clear   = flash_tValid || (flash_read_active != active_q);
    assign tmo_expired = !tmo_clear && (tmo_q == TMO_LAST);
    assign wr_accept   = (state_q == ST_LOAD) && flash_tValid && wr_idle && !count_full;
    assign wr_clear    = (state_q == ST_START);

    sram_byte_writer #(
        .ADDR_W    (MEM_ADDR_W),
        .BASE_ADDR (MEM_BASE),
        .WE_CYCLES (WE_CYCLES)
    ) u_writer (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (wr_clear),
        .valid_i    (wr_accept),
        .data_i     (flash_tData),
        .idle_o     (wr_idle),
        .done_o     (wr_done),
        .mem_addr_o (mem_addr),
        .mem_data_o (mem_data),
        .mem_ce_n_o (mem_ce_n),
        .mem_we_n_o (mem_we_n)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_START;
            err_cause_q   <= ERR_NONE;
            seen_active_q <= 1'b0;
            active_q      <= 1'b0;
            tmo_q         <= '0;
            byte_count_q  <= '0;
            checksum_q    <= '0;
            read_en_q     <= 1'b0;
            boot_done_q   <= 1'b0;
            boot_error_q  <= 1'b0;
            cpu_reset_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_cause_q   <= err_cause_d;
            seen_active_q <= seen_active_d;
            active_q      <= flash_read_active;
            tmo_q         <= tmo_d;
            byte_count_q  <= byte_count_d;
            checksum_q    <= checksum_d;
            read_en_q     <= read_en_d;
            boot_done_q   <= boot_done_d;
            boot_error_q  <= boot_error_d;
            cpu_reset_n_q <= cpu_reset_n_d;
        end
    end

    // START waits for any in-flight write so a retry never truncates a strobe.
    always_comb begin
        state_d     = state_q;
        err_cause_d = err_cause_q;
        case (state_q)
            ST_START: begin
                err_cause_d = ERR_NONE;
                if (wr_idle) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (tmo_expired) begin
                    state_d     = ST_ERROR;
                    err_cause_d = ERR_TIMEOUT;
                end else if (flash_tValid && !wr_idle) begin
                    state_d     = ST_ERROR;
                    err_cause_d = ERR_OVERRUN;
                end else if (flash_tValid && count_full) begin
                    state_d     = ST_ERROR;
                    err_cause_d = ERR_EXTRA;
                end else if (!flash_tValid && seen_active_q && !flash_read_active && wr_idle) begin
                    if (count_full) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_ERROR;
                        err_cause_d = ERR_SHORT;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (retry) begin
                    state_d     = ST_START;
                    err_cause_d = ERR_NONE;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        seen_active_d = seen_active_q;
        tmo_d         = tmo_q;
        byte_count_d  = byte_count_q;
        checksum_d    = checksum_q;
        if (state_q == ST_START) begin
            seen_active_d = 1'b0;
            tmo_d         = '0;
            byte_count_d  = '0;
            checksum_d    = '0;
        end else begin
            if (wr_done) begin
                byte_count_d = byte_count_q + 17'd1;
                checksum_d   = checksum_q + {8'h00, mem_data};
            end
            if (state_q == ST_LOAD) begin
                seen_active_d = seen_active_q | flash_read_active;
                if (tmo_clear)              tmo_d = '0;
                else if (tmo_q != TMO_LAST) tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // CPU release lags DONE entry by a cycle but drops together with the exit to START.
    always_comb begin
        read_en_d     = (state_d == ST_START) || (state_d == ST_LOAD);
        boot_done_d   = (state_q == ST_DONE) && (state_d == ST_DONE);
        cpu_reset_n_d = (state_q == ST_DONE) && (state_d == ST_DONE);
        boot_error_d  = (err_cause_d != ERR_NONE);
    end

    assign flash_read_en = read_en_q;
    assign boot_done     = boot_done_q;
    assign boot_error    = boot_error_q;
    assign cpu_reset_n   = cpu_reset_n_q;
    assign byte_count    = byte_count_q;
    assign checksum      = checksum_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Self-checking bench for flash_boot_loader: SRAM write scoreboard plus
// directed nominal, timing, overrun, short, extra, timeout and recovery scenarios.
module tb_flash_boot_loader;
    import flash_boot_pkg::*;

    localparam int NB   = 4;
    localparam int BASE = 256;
    localparam int AW   = 19;
    localparam int WEC  = 3;
    localparam int FREQ = 25000000;
    localparam int TUS  = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          retry = 1'b0;
    logic          flash_read_en;
    logic          flash_read_active = 1'b0;
    logic [7:0]    flash_tData = 8'h00;
    logic          flash_tValid = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_ce_n, mem_we_n, cpu_reset_n, boot_done, boot_error;
    logic [16:0]   byte_count;
    logic [15:0]   checksum;

    flash_boot_loader #(
        .CLOCK_FREQ_HZ (FREQ),
        .NUM_BYTES     (NB),
        .MEM_BASE      (BASE),
        .MEM_ADDR_W    (AW),
        .WE_CYCLES     (WEC),
        .TIMEOUT_US    (TUS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .retry             (retry),
        .flash_read_en     (flash_read_en),
        .flash_read_active (flash_read_active),
        .flash_tData       (flash_tData),
        .flash_tValid      (flash_tValid),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .mem_ce_n          (mem_ce_n),
        .mem_we_n          (mem_we_n),
        .cpu_reset_n       (cpu_reset_n),
        .boot_done         (boot_done),
        .boot_error        (boot_error),
        .byte_count        (byte_count),
        .checksum          (checksum)
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;
    wr_t expQ[$];
    logic [AW-1:0] addrExp = AW'(BASE);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit expectWrite);
        wr_t e;
        flash_tData  = b;
        flash_tValid = 1'b1;
        if (expectWrite) begin
            e.addr = addrExp;
            e.data = b;
            expQ.push_back(e);
            addrExp = addrExp + 1'b1;
        end
        tick();
        flash_tValid = 1'b0;
    endtask

    task automatic pulseRetry();
        retry = 1'b1;
        tick();
        retry   = 1'b0;
        addrExp = AW'(BASE);
    endtask

    task automatic waitState(input string tag, input boot_state_e st, input int maxCycles);
        int n = 0;
        while (dut.state_q != st && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(dut.state_q), 32'(st));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_en"},  32'(flash_read_en), 32'(0));
        checkOutput({tag, "_ce_n"},   32'(mem_ce_n), 32'(1));
        checkOutput({tag, "_we_n"},   32'(mem_we_n), 32'(1));
        checkOutput({tag, "_cpu_rn"}, 32'(cpu_reset_n), 32'(0));
        checkOutput({tag, "_done"},   32'(boot_done), 32'(0));
        checkOutput({tag, "_error"},  32'(boot_error), 32'(0));
        checkOutput({tag, "_addr"},   32'(mem_addr), 32'(BASE));
        checkOutput({tag, "_data"},   32'(mem_data), 32'h0FF);
        checkOutput({tag, "_count"},  32'(byte_count), 32'(0));
        checkOutput({tag, "_csum"},   32'(checksum), 32'(0));
    endtask

    // Every completed WE pulse is matched against the next expected write.
    int            weRun = 0;
    logic [AW-1:0] runAddr;
    logic [7:0]    runData;
    always @(negedge clock) begin
        wr_t e;
        if (reset) begin
            weRun = 0;
        end else if (!mem_we_n) begin
            if (weRun == 0) begin
                runAddr = mem_addr;
                runData = mem_data;
            end
            weRun++;
            checkOutput("ce_during_we", 32'(mem_ce_n), 32'(0));
        end else if (weRun > 0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 32'(expQ.size()), 32'(1));
            end else begin
                e = expQ.pop_front();
                checkOutput("wr_addr", 32'(runAddr), 32'(e.addr));
                checkOutput("wr_data", 32'(runData), 32'(e.data));
                checkOutput("we_len", 32'(weRun), 32'(WEC));
            end
            weRun = 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] nomBytes [4];
        logic [7:0] ceV, weV;
        int n, rdAt, errAt;
        nomBytes[0] = 8'h11; nomBytes[1] = 8'h22; nomBytes[2] = 8'h33; nomBytes[3] = 8'h44;

        repeat (3) tick();
        checkResetValues("reset");

        // Timeout: the reader never activates after reset releases.
        reset = 1'b0;
        n = 0; rdAt = -1; errAt = -1;
        while (errAt < 0 && n < 60) begin
            tick();
            n++;
            if (flash_read_en && rdAt < 0) rdAt = n;
            if (boot_error && errAt < 0)   errAt = n;
        end
        checkOutput("tmo_latency", 32'(errAt - rdAt), 32'(25));
        checkOutput("tmo_cause", 32'(dut.err_cause_q), 32'(ERR_TIMEOUT));
        checkOutput("tmo_cpu_rn", 32'(cpu_reset_n), 32'(0));
        checkOutput("tmo_rd_en", 32'(flash_read_en), 32'(0));

        // Recovery into a nominal load.
        pulseRetry();
        checkOutput("retry_state", 32'(dut.state_q), 32'(ST_START));
        checkOutput("retry_rd_en", 32'(flash_read_en), 32'(1));
        repeat (2) tick();
        flash_read_active = 1'b1;
        tick();
        for (int i = 0; i < NB; i++) begin
            applyStimulus(nomBytes[i], 1'b1);
            repeat (19) tick();
        end
        flash_read_active = 1'b0;
        waitState("nom_done_state", ST_DONE, 20);
        checkOutput("nom_done_entry", 32'(boot_done), 32'(0));
        tick();
        checkOutput("nom_done", 32'(boot_done), 32'(1));
        checkOutput("nom_cpu_rn", 32'(cpu_reset_n), 32'(1));
        checkOutput("nom_count", 32'(byte_count), 32'(4));
        checkOutput("nom_csum", 32'(checksum), 32'h00AA);
        checkOutput("nom_addr", 32'(mem_addr), 32'(BASE + 4));
        checkOutput("nom_sb_empty", 32'(expQ.size()), 32'(0));

        // Bytes outside LOAD are dropped.
        applyStimulus(8'hEE, 1'b0);
        repeat (6) tick();
        checkOutput("ignored_count", 32'(byte_count), 32'(4));

        pulseRetry();
        checkOutput("redo_cpu_rn", 32'(cpu_reset_n), 32'(0));
        checkOutput("redo_state", 32'(dut.state_q), 32'(ST_START));
        tick();
        flash_read_active = 1'b1;
        tick();

        // Strobe timing around a single byte.
        flash_tData  = 8'h5A;
        flash_tValid = 1'b1;
        expQ.push_back('{addr: addrExp, data: 8'h5A});
        addrExp = addrExp + 1'b1;
        ceV[0] = mem_ce_n;
        weV[0] = mem_we_n;
        for (int k = 1; k < 8; k++) begin
            tick();
            flash_tValid = 1'b0;
            ceV[k] = mem_ce_n;
            weV[k] = mem_we_n;
        end
        checkOutput("strobe_ce_n", 32'(ceV), 32'h0C1);
        checkOutput("strobe_we_n", 32'(weV), 32'h0E3);

        // Overrun: second byte two cycles after the first.
        applyStimulus(8'h66, 1'b1);
        tick();
        applyStimulus(8'h77, 1'b0);
        checkOutput("ovr_error", 32'(boot_error), 32'(1));
        checkOutput("ovr_cause", 32'(dut.err_cause_q), 32'(ERR_OVERRUN));
        repeat (6) tick();
        checkOutput("ovr_cpu_rn", 32'(cpu_reset_n), 32'(0));
        checkOutput("ovr_count", 32'(byte_count), 32'(2));
        checkOutput("ovr_csum", 32'(checksum), 32'h00C0);

        // Short stream: three of four bytes.
        flash_read_active = 1'b0;
        pulseRetry();
        tick();
        flash_read_active = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(8'(i), 1'b1);
            repeat (9) tick();
        end
        flash_read_active = 1'b0;
        waitState("short_state", ST_ERROR, 20);
        checkOutput("short_cause", 32'(dut.err_cause_q), 32'(ERR_SHORT));
        checkOutput("short_count", 32'(byte_count), 32'(3));
        checkOutput("short_csum", 32'(checksum), 32'h0006);
        tick();
        checkOutput("short_rd_en", 32'(flash_read_en), 32'(0));

        // Extra byte after the full count.
        pulseRetry();
        tick();
        flash_read_active = 1'b1;
        tick();
        for (int i = 0; i < NB; i++) begin
            applyStimulus(8'h80 + 8'(i), 1'b1);
            repeat (9) tick();
        end
        applyStimulus(8'h99, 1'b0);
        checkOutput("extra_state", 32'(dut.state_q), 32'(ST_ERROR));
        checkOutput("extra_cause", 32'(dut.err_cause_q), 32'(ERR_EXTRA));
        repeat (6) tick();
        checkOutput("extra_count", 32'(byte_count), 32'(4));

        // Reset in the middle of a load.
        flash_read_active = 1'b0;
        pulseRetry();
        tick();
        flash_read_active = 1'b1;
        tick();
        applyStimulus(8'hAB, 1'b1);
        repeat (9) tick();
        retry = 1'b1;
        tick();
        retry = 1'b0;
        checkOutput("retry_in_load", 32'(dut.state_q), 32'(ST_LOAD));
        checkOutput("mid_count", 32'(byte_count), 32'(1));
        reset = 1'b1;
        tick();
        checkResetValues("midrst");
        checkOutput("final_sb_empty", 32'(expQ.size()), 32'(0));
        reset = 1'b0;
        flash_read_active = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
